divider_16x8: RTL
=================

// Module: divider_16x8
// PURPOSE
//   Sequential restoring divider: 16-bit dividend / 8-bit divisor -> 16-bit quotient + 8-bit remainder.
//   Inverse datapath companion to the 8x8 sequential multiplier; same start/done_flag/seven_segment
//   control style so both units share one top-level harness and display.
//   Radix-2: one quotient bit per clock, 16 iterations, plus explicit divide-by-zero detection.
// PARAMETERS
//   DIVIDEND_W      16  dividend/quotient width; iteration count = DIVIDEND_W
//   DIVISOR_W       8   divisor/remainder width
//   SEG_ACTIVE_LOW  0   1 = invert seven_segment outputs (common-anode display)
// PORTS
//   clk             in   1   rising-edge clock
//   reset_a         in   1   asynchronous, active-high reset
//   start           in   1   request; sampled on rising clk in IDLE, DONE or ERR
//   data_a          in   16  dividend, captured on accepted start
//   data_b          in   8   divisor, captured on accepted start
//   busy            out  1   high while in CALC
//   done_flag       out  1   high while in DONE or ERR
//   div_by_zero     out  1   high while in ERR
//   quotient_out    out  16  registered quotient, valid while done_flag=1
//   remainder_out   out  8   registered remainder, valid while done_flag=1
//   seven_segment   out  7   state glyph, bit order {g,f,e,d,c,b,a}
// BEHAVIOUR
//   Reset (reset_a=1, async): state=IDLE, counter=0, busy=0, done_flag=0, div_by_zero=0,
//     quotient_out=0, remainder_out=0, internal regs=0; seven_segment=IDLE glyph immediately.
//   Reset mid-operation aborts the division; no partial result is ever presented.
//   States: IDLE, CALC, DONE, ERR (2-bit encoding, free choice).
//   IDLE/DONE/ERR on edge with start=1:
//     data_b==0 -> ERR; quotient_out=16'hFFFF, remainder_out=0, div_by_zero=1, done_flag=1.
//     else      -> CALC; latch Q<=data_a, D<=data_b, R(9b)<=0, counter<=0.
//   start=0 in DONE/ERR: hold state and outputs indefinitely.
//   CALC, each edge: T={R[7:0],Q[15]}; Q<={Q[14:0],T>=D}; R<=(T>=D)?T-D:T; counter<=counter+1.
//     R is 9 bits so the shifted value is compared before any truncation; after subtraction R<D<=255.
//     On the 16th CALC edge (counter==15): load quotient_out/remainder_out from the final Q/R
//     values and go to DONE.
//   Latency: start accepted at edge k -> done_flag=1 and result valid after edge k+16.
//   start in CALC is ignored (no restart, no queueing); data_a/data_b changes in CALC are ignored.
//   quotient_out/remainder_out update only on entry to DONE or ERR; they hold through the next
//     CALC until the new result is written.
//   seven_segment (SEG_ACTIVE_LOW=0): IDLE '0'=7'b0111111, CALC '1'=7'b0000110,
//     DONE '2'=7'b1011011, ERR 'E'=7'b1111001; combinational decode of state, glitch-free.
//   Invariant checked in DONE: quotient_out*data_b_latched + remainder_out == dividend_latched,
//     and remainder_out < divisor.
// TESTING
//   1. data_a=1000, data_b=7, start 1 cycle -> busy 16 cycles; done_flag after edge k+16; q=142, r=6.
//   2. data_a=16'hFFFF, data_b=8'hFF -> q=16'h0101, r=0; seg shows '2' while done.
//   3. data_a=5, data_b=9 (divisor > dividend) -> q=0, r=5.
//   4. data_b=0, data_a=1234 -> ERR next edge: div_by_zero=1, done_flag=1, q=16'hFFFF, r=0, seg 'E'.
//   5. 40000/3, assert reset_a after 8 CALC edges -> all outputs 0 at once, IDLE; then
//      200/10 -> q=20, r=0.
//   6. Hold start high during CALC of 100/3 (ignored) -> q=33, r=1; then start in DONE with
//      65535/1 -> q=65535, r=0 after 16 more edges.

Source files
------------

// File: rtl/divider_16x8.sv
// Sequential restoring divider: DIVIDEND_W-bit dividend / DIVISOR_W-bit divisor, one quotient
// bit per clock, with divide-by-zero detection and a state glyph for a seven-segment display.
module divider_16x8 #(
  parameter int DIVIDEND_W     = 16,
  parameter int DIVISOR_W      = 8,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  reset_a,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] data_a,
  input  logic [DIVISOR_W-1:0]  data_b,
  output logic                  busy,
  output logic                  done_flag,
  output logic                  div_by_zero,
  output logic [DIVIDEND_W-1:0] quotient_out,
  output logic [DIVISOR_W-1:0]  remainder_out,
  output logic [6:0]            seven_segment
);

  // Handshake: start is taken on any rising edge while not busy (IDLE, DONE or ERR) and is
  // ignored in CALC; the result is held on quotient_out/remainder_out while done_flag is high.

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE, S_ERR} state_t;

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

  state_t                 state, state_nxt;
  logic [DIVIDEND_W-1:0]  q_reg;
  logic [DIVISOR_W-1:0]   d_reg;
  logic [DIVISOR_W-1:0]   r_reg;
  logic [CNT_W-1:0]       count;

  logic [DIVISOR_W:0]     trial;
  logic                   fits;
  logic [DIVISOR_W-1:0]   r_nxt;
  logic [DIVIDEND_W-1:0]  q_nxt;
  logic                   last_step;
  logic                   zero_div;
  logic [6:0]             glyph;

  // The remainder always stays below the divisor, so the extra bit lives only in the trial
  // value; the subtraction result fits in DIVISOR_W bits whenever it is taken.
  always_comb begin
    trial     = {r_reg, q_reg[DIVIDEND_W-1]};
    fits      = (trial >= {1'b0, d_reg});
    r_nxt     = fits ? (trial[DIVISOR_W-1:0] - d_reg) : trial[DIVISOR_W-1:0];
    q_nxt     = {q_reg[DIVIDEND_W-2:0], fits};
    last_step = (count == LAST_CNT);
    zero_div  = (data_b == '0);
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CALC:  if (last_step) state_nxt = S_DONE;
      default: if (start)     state_nxt = zero_div ? S_ERR : S_CALC;
    endcase
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      q_reg         <= '0;
      d_reg         <= '0;
      r_reg         <= '0;
      count         <= '0;
      quotient_out  <= '0;
      remainder_out <= '0;
    end else begin
      case (state)
        S_CALC: begin
          q_reg <= q_nxt;
          r_reg <= r_nxt;
          count <= count + 1'b1;
          if (last_step) begin
            quotient_out  <= q_nxt;
            remainder_out <= r_nxt;
          end
        end
        default: begin
          if (start) begin
            if (zero_div) begin
              quotient_out  <= '1;
              remainder_out <= '0;
            end else begin
              q_reg <= data_a;
              d_reg <= data_b;
              r_reg <= '0;
              count <= '0;
            end
          end
        end
      endcase
    end
  end

  assign busy        = (state == S_CALC);
  assign done_flag   = (state == S_DONE) || (state == S_ERR);
  assign div_by_zero = (state == S_ERR);

  // Glyph bit order {g,f,e,d,c,b,a}; decoded straight from the state register.
  always_comb begin
    glyph = 7'b0111111;
    case (state)
      S_IDLE: glyph = 7'b0111111;
      S_CALC: glyph = 7'b0000110;
      S_DONE: glyph = 7'b1011011;
      S_ERR:  glyph = 7'b1111001;
      default: glyph = 7'b0111111;
    endcase
    seven_segment = (SEG_ACTIVE_LOW != 0) ? ~glyph : glyph;
  end

endmodule
